axi_i2c_txn_sched: RTL and testbench



---
 rtl/axi_i2c_pkg.sv | 40 ++++
 rtl/axi_i2c_req_capture.sv | 76 +++++++
 rtl/axi_i2c_txn_sched.sv | 219 +++++++++++++++++++++
 tb/tb_axi_i2c_txn_sched.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_i2c_pkg.sv
// Shared types and constants for the AXI-to-I2C transaction scheduler.
// Bus widths come from the ADDR_WIDTH/DATA_WIDTH/RDATA_WIDTH/RESPONSE_WIDTH macros, defaulted here if absent.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef RDATA_WIDTH
`define RDATA_WIDTH 32
`endif
`ifndef RESPONSE_WIDTH
`define RESPONSE_WIDTH 2
`endif

package axi_i2c_pkg;

  localparam int ADDR_W  = `ADDR_WIDTH;
  localparam int DATA_W  = `DATA_WIDTH;
  localparam int RDATA_W = `RDATA_WIDTH;
  localparam int RESP_W  = `RESPONSE_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic [RESP_W-1:0] RESP_OKAY   = RESP_W'(2'b00);
  localparam logic [RESP_W-1:0] RESP_SLVERR = RESP_W'(2'b10);

  // Address map: ADDR[14:8] is the I2C device, ADDR[7:0] the register.
  localparam int DEV_MSB   = 14;
  localparam int DEV_LSB   = 8;
  localparam int REG_MSB   = 7;
  localparam int REG_LSB   = 0;
  localparam int WBYTE_MSB = 7;

endpackage

// File: rtl/axi_i2c_req_capture.sv
// Hold registers for the AW, W and AR channels. Each channel is ready while its
// hold flag is clear and latches independently; the scheduler clears flags on response.
module axi_i2c_req_capture
  import axi_i2c_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                aw_valid_i,
  input  logic [ADDR_W-1:0]   aw_addr_i,
  output logic                aw_ready_o,
  input  logic                w_valid_i,
  input  logic [DATA_W-1:0]   w_data_i,
  output logic                w_ready_o,
  input  logic                ar_valid_i,
  input  logic [ADDR_W-1:0]   ar_addr_i,
  output logic                ar_ready_o,
  input  logic                clr_wr_i,
  input  logic                clr_rd_i,
  output logic                aw_held_o,
  output logic                w_held_o,
  output logic                ar_held_o,
  output logic [DEV_MSB:0]    aw_addr_o,
  output logic [WBYTE_MSB:0]  w_byte_o,
  output logic [DEV_MSB:0]    ar_addr_o
);

  logic               aw_held_q, w_held_q, ar_held_q;
  logic [DEV_MSB:0]   aw_addr_q, ar_addr_q;
  logic [WBYTE_MSB:0] w_byte_q;

  // Only the low address/data bits carry meaning; the rest are dropped on capture.
  logic unused_hi_bits;
  assign unused_hi_bits = ^{aw_addr_i, w_data_i, ar_addr_i};

  assign aw_ready_o = !aw_held_q;
  assign w_ready_o  = !w_held_q;
  assign ar_ready_o = !ar_held_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      ar_held_q <= 1'b0;
      aw_addr_q <= '0;
      w_byte_q  <= '0;
      ar_addr_q <= '0;
    end else begin
      if (aw_valid_i && !aw_held_q) begin
        aw_held_q <= 1'b1;
        aw_addr_q <= aw_addr_i[DEV_MSB:0];
      end else if (clr_wr_i) begin
        aw_held_q <= 1'b0;
      end
      if (w_valid_i && !w_held_q) begin
        w_held_q <= 1'b1;
        w_byte_q <= w_data_i[WBYTE_MSB:0];
      end else if (clr_wr_i) begin
        w_held_q <= 1'b0;
      end
      if (ar_valid_i && !ar_held_q) begin
        ar_held_q <= 1'b1;
        ar_addr_q <= ar_addr_i[DEV_MSB:0];
      end else if (clr_rd_i) begin
        ar_held_q <= 1'b0;
      end
    end
  end

  assign aw_held_o = aw_held_q;
  assign w_held_o  = w_held_q;
  assign ar_held_o = ar_held_q;
  assign aw_addr_o = aw_addr_q;
  assign w_byte_o  = w_byte_q;
  assign ar_addr_o = ar_addr_q;

endmodule

// File: rtl/axi_i2c_txn_sched.sv
// AXI4-Lite front end and round-robin scheduler issuing one I2C register command at a time.
// Define I2C_TIMEOUT_EN to add the engine completion timeout with cmd_abort.
module axi_i2c_txn_sched
  import axi_i2c_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic               ACLK,
  input  logic               ARESETn,
  input  logic               AWVALID,
  output logic               AWREADY,
  input  logic [ADDR_W-1:0]  AWADDR,
  input  logic               WVALID,
  output logic               WREADY,
  input  logic [DATA_W-1:0]  WDATA,
  output logic               BVALID,
  input  logic               BREADY,
  output logic [RESP_W-1:0]  BRESP,
  input  logic               ARVALID,
  output logic               ARREADY,
  input  logic [ADDR_W-1:0]  ARADDR,
  output logic               RVALID,
  input  logic               RREADY,
  output logic [RDATA_W-1:0] RDATA,
  output logic [RESP_W-1:0]  RRESP,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic               cmd_rw,
  output logic [6:0]         cmd_dev,
  output logic [7:0]         cmd_reg,
  output logic [7:0]         cmd_wdata,
  output logic               cmd_abort,
  input  logic               eng_done,
  input  logic               eng_nack,
  input  logic [7:0]         eng_rdata,
  output logic [1:0]         dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; valid, once raised, holds with stable payload until that edge, and no
  // valid output is derived combinationally from its ready.

  logic               aw_held, w_held, ar_held;
  logic [DEV_MSB:0]   aw_addr, ar_addr;
  logic [WBYTE_MSB:0] w_byte;
  logic               wr_elig, rd_elig, resp_hs, clr_wr, clr_rd;
  logic               to_hit, expire;

  state_e              state_q, state_d;
  logic                prio_q, prio_d;
  logic                cmd_rw_q, cmd_rw_d;
  logic [6:0]          cmd_dev_q, cmd_dev_d;
  logic [7:0]          cmd_reg_q, cmd_reg_d;
  logic [7:0]          cmd_wdata_q, cmd_wdata_d;
  logic [RESP_W-1:0]   bresp_q, bresp_d, rresp_q, rresp_d;
  logic [RDATA_W-1:0]  rdata_q, rdata_d;

  axi_i2c_req_capture u_capture (
    .clk_i      (ACLK),
    .rst_ni     (ARESETn),
    .aw_valid_i (AWVALID),
    .aw_addr_i  (AWADDR),
    .aw_ready_o (AWREADY),
    .w_valid_i  (WVALID),
    .w_data_i   (WDATA),
    .w_ready_o  (WREADY),
    .ar_valid_i (ARVALID),
    .ar_addr_i  (ARADDR),
    .ar_ready_o (ARREADY),
    .clr_wr_i   (clr_wr),
    .clr_rd_i   (clr_rd),
    .aw_held_o  (aw_held),
    .w_held_o   (w_held),
    .ar_held_o  (ar_held),
    .aw_addr_o  (aw_addr),
    .w_byte_o   (w_byte),
    .ar_addr_o  (ar_addr)
  );

  assign wr_elig = aw_held && w_held;
  assign rd_elig = ar_held;
  assign resp_hs = (state_q == ST_RESP) && (cmd_rw_q ? RREADY : BREADY);
  assign clr_wr  = resp_hs && !cmd_rw_q;
  assign clr_rd  = resp_hs && cmd_rw_q;
  // A completion landing in the same cycle as the timeout wins.
  assign expire  = to_hit && ((state_q == ST_ISSUE) || (state_q == ST_WAIT && !eng_done));

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    cmd_rw_d    = cmd_rw_q;
    cmd_dev_d   = cmd_dev_q;
    cmd_reg_d   = cmd_reg_q;
    cmd_wdata_d = cmd_wdata_q;
    bresp_d     = bresp_q;
    rresp_d     = rresp_q;
    rdata_d     = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_elig && (!rd_elig || !prio_q)) begin
          state_d     = ST_ISSUE;
          cmd_rw_d    = 1'b0;
          cmd_dev_d   = aw_addr[DEV_MSB:DEV_LSB];
          cmd_reg_d   = aw_addr[REG_MSB:REG_LSB];
          cmd_wdata_d = w_byte;
        end else if (rd_elig) begin
          state_d     = ST_ISSUE;
          cmd_rw_d    = 1'b1;
          cmd_dev_d   = ar_addr[DEV_MSB:DEV_LSB];
          cmd_reg_d   = ar_addr[REG_MSB:REG_LSB];
          cmd_wdata_d = '0;
        end
      end
      ST_ISSUE: begin
        if (cmd_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (eng_done) begin
          state_d = ST_RESP;
          if (cmd_rw_q) begin
            rresp_d = eng_nack ? RESP_SLVERR : RESP_OKAY;
            rdata_d = RDATA_W'(eng_rdata);
          end else begin
            bresp_d = eng_nack ? RESP_SLVERR : RESP_OKAY;
          end
        end
      end
      ST_RESP: begin
        if (resp_hs) begin
          state_d = ST_IDLE;
          prio_d  = ~prio_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (expire) begin
      state_d = ST_RESP;
      if (cmd_rw_q) begin
        rresp_d = RESP_SLVERR;
        rdata_d = '0;
      end else begin
        bresp_d = RESP_SLVERR;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= ST_IDLE;
      prio_q      <= 1'b0;
      cmd_rw_q    <= 1'b0;
      cmd_dev_q   <= '0;
      cmd_reg_q   <= '0;
      cmd_wdata_q <= '0;
      bresp_q     <= RESP_OKAY;
      rresp_q     <= RESP_OKAY;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      cmd_rw_q    <= cmd_rw_d;
      cmd_dev_q   <= cmd_dev_d;
      cmd_reg_q   <= cmd_reg_d;
      cmd_wdata_q <= cmd_wdata_d;
      bresp_q     <= bresp_d;
      rresp_q     <= rresp_d;
      rdata_q     <= rdata_d;
    end
  end

`ifdef I2C_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             abort_q;

  assign to_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Held at zero in IDLE so it always starts fresh on entering ISSUE.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_IDLE) begin
      cnt_d = '0;
    end else if (state_q == ST_ISSUE || state_q == ST_WAIT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      abort_q <= expire;
    end
  end

  assign cmd_abort = abort_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign to_hit    = 1'b0;
  assign cmd_abort = 1'b0;
`endif

  assign cmd_valid   = (state_q == ST_ISSUE);
  assign BVALID      = (state_q == ST_RESP) && !cmd_rw_q;
  assign RVALID      = (state_q == ST_RESP) && cmd_rw_q;
  assign BRESP       = bresp_q;
  assign RRESP       = rresp_q;
  assign RDATA       = rdata_q;
  assign cmd_rw      = cmd_rw_q;
  assign cmd_dev     = cmd_dev_q;
  assign cmd_reg     = cmd_reg_q;
  assign cmd_wdata   = cmd_wdata_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_axi_i2c_txn_sched.sv
// Directed self-checking bench for axi_i2c_txn_sched; the timeout section runs
// only when I2C_TIMEOUT_EN is defined (TIMEOUT_CYCLES = 16 here).
module tb_axi_i2c_txn_sched;
  import axi_i2c_pkg::*;

  logic               ACLK = 1'b0;
  logic               ARESETn;
  logic               AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic [ADDR_W-1:0]  AWADDR, ARADDR;
  logic [DATA_W-1:0]  WDATA;
  logic [RESP_W-1:0]  BRESP, RRESP;
  logic               ARVALID, ARREADY, RVALID, RREADY;
  logic [RDATA_W-1:0] RDATA;
  logic               cmd_valid, cmd_ready, cmd_rw, cmd_abort;
  logic [6:0]         cmd_dev;
  logic [7:0]         cmd_reg, cmd_wdata;
  logic               eng_done, eng_nack;
  logic [7:0]         eng_rdata;
  logic [1:0]         dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Clock and reset
  always #5 ACLK = ~ACLK;

  axi_i2c_txn_sched #(.TIMEOUT_CYCLES(16)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_dev(cmd_dev), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
    .cmd_abort(cmd_abort), .eng_done(eng_done), .eng_nack(eng_nack),
    .eng_rdata(eng_rdata), .dbg_state_o(dbg_state)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, required end before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(negedge ACLK);
  endtask

  task automatic idle_inputs();
    AWVALID = 0; AWADDR = '0; WVALID = 0; WDATA = '0; BREADY = 0;
    ARVALID = 0; ARADDR = '0; RREADY = 0;
    cmd_ready = 0; eng_done = 0; eng_nack = 0; eng_rdata = '0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk($sformatf("%s awready", tag), AWREADY, 1);
    chk($sformatf("%s wready", tag), WREADY, 1);
    chk($sformatf("%s arready", tag), ARREADY, 1);
    chk($sformatf("%s bvalid", tag), BVALID, 0);
    chk($sformatf("%s rvalid", tag), RVALID, 0);
    chk($sformatf("%s cmd_valid", tag), cmd_valid, 0);
    chk($sformatf("%s cmd_abort", tag), cmd_abort, 0);
    chk($sformatf("%s bresp", tag), BRESP, 0);
    chk($sformatf("%s rresp", tag), RRESP, 0);
    chk($sformatf("%s rdata", tag), RDATA, 0);
    chk($sformatf("%s cmd_rw", tag), cmd_rw, 0);
    chk($sformatf("%s cmd_dev", tag), cmd_dev, 0);
    chk($sformatf("%s cmd_reg", tag), cmd_reg, 0);
    chk($sformatf("%s cmd_wdata", tag), cmd_wdata, 0);
    chk($sformatf("%s state", tag), dbg_state, 0);
  endtask

  task automatic send_aw_w(input logic [31:0] addr, input logic [31:0] data);
    AWVALID = 1; AWADDR = ADDR_W'(addr); WVALID = 1; WDATA = DATA_W'(data);
  endtask

  task automatic send_ar(input logic [31:0] addr);
    ARVALID = 1; ARADDR = ADDR_W'(addr);
  endtask

  task automatic drop_valids();
    AWVALID = 0; WVALID = 0; ARVALID = 0;
  endtask

  // Called on the cycle a command is expected on the engine port; runs it to the response handshake.
  task automatic serve(input string tag, input logic rw, input logic [6:0] dev,
                       input logic [7:0] rg, input logic [7:0] wb,
                       input logic nack, input logic [7:0] rd);
    chk($sformatf("%s cmd_valid", tag), cmd_valid, 1);
    chk($sformatf("%s cmd_rw", tag), cmd_rw, rw);
    chk($sformatf("%s cmd_dev", tag), cmd_dev, dev);
    chk($sformatf("%s cmd_reg", tag), cmd_reg, rg);
    if (!rw) chk($sformatf("%s cmd_wdata", tag), cmd_wdata, wb);
    cmd_ready = 1; step(); cmd_ready = 0;
    chk($sformatf("%s wait cmd_valid", tag), cmd_valid, 0);
    eng_done = 1; eng_nack = nack; eng_rdata = rd;
    step();
    eng_done = 0; eng_nack = 0; eng_rdata = '0;
    chk($sformatf("%s bvalid", tag), BVALID, !rw);
    chk($sformatf("%s rvalid", tag), RVALID, rw);
    if (rw) begin
      chk($sformatf("%s rresp", tag), RRESP, nack ? 2 : 0);
      chk($sformatf("%s rdata", tag), RDATA, rd);
      RREADY = 1;
    end else begin
      chk($sformatf("%s bresp", tag), BRESP, nack ? 2 : 0);
      BREADY = 1;
    end
    step();
    RREADY = 0; BREADY = 0;
    chk($sformatf("%s bvalid after", tag), BVALID, 0);
    chk($sformatf("%s rvalid after", tag), RVALID, 0);
  endtask

  initial begin
    idle_inputs();
    ARESETn = 0;
    step();
    chk_reset_vals("reset");
    ARESETn = 1;
    step();

    // Single write
    send_aw_w(32'h0000_5A10, 32'h0000_003C);
    step(); drop_valids();
    chk("wr1 awready held", AWREADY, 0);
    chk("wr1 wready held", WREADY, 0);
    chk("wr1 grant cycle cmd_valid", cmd_valid, 0);
    step();
    chk("wr1 first issue cmd_valid", cmd_valid, 1);
    step();
    serve("wr1", 0, 7'h5A, 8'h10, 8'h3C, 0, 8'h00);
    chk("wr1 awready released", AWREADY, 1);
    chk("wr1 wready released", WREADY, 1);

    // Stray completion in IDLE is ignored
    eng_done = 1; eng_nack = 1; eng_rdata = 8'h99;
    step();
    eng_done = 0; eng_nack = 0; eng_rdata = '0;
    chk("stray bvalid", BVALID, 0);
    chk("stray rvalid", RVALID, 0);
    chk("stray state", dbg_state, 0);
    chk("stray rdata", RDATA, 0);

    // Read with NACK
    send_ar(32'h0000_2001);
    step(); drop_valids();
    chk("rd1 arready held", ARREADY, 0);
    step();
    serve("rd1", 1, 7'h20, 8'h01, 8'h00, 1, 8'hFF);
    chk("rd1 arready released", ARREADY, 1);

    // W three cycles ahead of AW; stalled B response
    WVALID = 1; WDATA = 32'hDEAD_BEA5;
    step(); WVALID = 0;
    chk("wfirst wready held", WREADY, 0);
    chk("wfirst no cmd 1", cmd_valid, 0);
    step();
    chk("wfirst no cmd 2", cmd_valid, 0);
    step();
    chk("wfirst no cmd 3", cmd_valid, 0);
    AWVALID = 1; AWADDR = ADDR_W'(32'hFFFF_7F80);
    step(); AWVALID = 0;
    chk("wfirst awready held", AWREADY, 0);
    chk("wfirst grant cycle", cmd_valid, 0);
    step();
    chk("wfirst cmd_valid", cmd_valid, 1);
    chk("wfirst cmd_rw", cmd_rw, 0);
    chk("wfirst cmd_dev", cmd_dev, 7'h7F);
    chk("wfirst cmd_reg", cmd_reg, 8'h80);
    chk("wfirst cmd_wdata", cmd_wdata, 8'hA5);
    cmd_ready = 1; step(); cmd_ready = 0;
    chk("wfirst awready in wait", AWREADY, 0);
    send_ar(32'h0000_0142);
    eng_done = 1; eng_nack = 1;
    step();
    drop_valids(); eng_done = 0; eng_nack = 0;
    chk("stall bvalid", BVALID, 1);
    chk("stall bresp", BRESP, 2);
    chk("stall ar captured", ARREADY, 0);
    chk("stall awready", AWREADY, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("stall%0d bvalid", i), BVALID, 1);
      chk($sformatf("stall%0d bresp", i), BRESP, 2);
      chk($sformatf("stall%0d no cmd", i), cmd_valid, 0);
    end
    BREADY = 1;
    step(); BREADY = 0;
    chk("stall bvalid done", BVALID, 0);
    chk("stall awready released", AWREADY, 1);
    chk("stall wready released", WREADY, 1);
    step();
    serve("rd2", 1, 7'h01, 8'h42, 8'h00, 0, 8'h37);

    // Simultaneous pairs: from reset the write wins; after one more write the read wins
    ARESETn = 0; step(); ARESETn = 1; step();
    send_aw_w(32'h0000_1155, 32'h0000_0066);
    send_ar(32'h0000_0A0B);
    step(); drop_valids();
    chk("pair1 awready", AWREADY, 0);
    chk("pair1 arready", ARREADY, 0);
    step();
    serve("pair1 wr", 0, 7'h11, 8'h55, 8'h66, 0, 8'h00);
    step();
    serve("pair1 rd", 1, 7'h0A, 8'h0B, 8'h00, 0, 8'h5C);
    send_aw_w(32'h0000_0C0D, 32'h0000_0077);
    step(); drop_valids();
    step();
    serve("solo wr", 0, 7'h0C, 8'h0D, 8'h77, 0, 8'h00);
    send_aw_w(32'h0000_3344, 32'h0000_0088);
    send_ar(32'h0000_5566);
    step(); drop_valids();
    step();
    serve("pair2 rd", 1, 7'h55, 8'h66, 8'h00, 0, 8'h12);
    step();
    serve("pair2 wr", 0, 7'h33, 8'h44, 8'h88, 1, 8'h00);

    // Asynchronous reset while waiting on the engine
    send_aw_w(32'h0000_4321, 32'h0000_0011);
    step(); drop_valids();
    step();
    cmd_ready = 1; step(); cmd_ready = 0;
    chk("rst state wait", dbg_state, 2);
    chk("rst cmd_dev before", cmd_dev, 7'h43);
    #2 ARESETn = 0;
    #1;
    chk_reset_vals("async reset");
    step(); ARESETn = 1; step();

`ifdef I2C_TIMEOUT_EN
    send_ar(32'h0000_0777);
    step(); drop_valids();
    step();
    serve("pre-to rd", 1, 7'h07, 8'h77, 8'h00, 0, 8'hAB);
    send_ar(32'h0000_1234);
    step(); drop_valids();
    step();
    chk("to cmd_valid", cmd_valid, 1);
    chk("to cmd_dev", cmd_dev, 7'h12);
    cmd_ready = 1; step(); cmd_ready = 0;
    chk("to state wait", dbg_state, 2);
    for (int i = 2; i <= 15; i++) begin
      step();
      chk($sformatf("to%0d abort", i), cmd_abort, 0);
      chk($sformatf("to%0d rvalid", i), RVALID, 0);
    end
    step();
    chk("to abort pulse", cmd_abort, 1);
    chk("to cmd_valid dropped", cmd_valid, 0);
    chk("to rvalid", RVALID, 1);
    chk("to rresp", RRESP, 2);
    chk("to rdata", RDATA, 0);
    step();
    chk("to abort single", cmd_abort, 0);
    chk("to rvalid held", RVALID, 1);
    RREADY = 1; step(); RREADY = 0;
    chk("to rvalid done", RVALID, 0);
    chk("to arready", ARREADY, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
